// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-domain consumer for the async FIFO.
// Pops the FIFO, captures the registered data one cycle later into a
// 3-entry buffer and re-presents it as a valid/ready stream with burst framing.
module fifo_rd_streamer #(
    parameter int unsigned FIFO_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  rdclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              occ;
    logic [1:0]              head;
    logic [1:0]              tail;
    logic                    inflight;
    logic                    last_q;
    logic [BEAT_W-1:0]       issue_beat;
    logic [FIFO_WIDTH-1:0]   buf_data [DEPTH];
    logic                    buf_last [DEPTH];

    logic                    issue_ok;
    logic                    beat_last;
    logic                    pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign beat_last = (issue_beat == BEAT_W'(BURST_LEN - 1));
    assign issue_ok  = (state == RUN) || ((state == DRAIN) && (issue_beat != '0));
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf_data[head];
    assign m_last    = buf_last[head];
    assign busy      = (state != IDLE);
    assign pop       = m_valid && m_ready;

    // Pop request: only from registered state and the FIFO flag; the
    // occ+inflight bound keeps room for every word already requested.
    always_comb begin
        rd_en = 1'b0;
        if (rrst_n && issue_ok && !fifo_empty &&
            (({1'b0, occ} + {2'b00, inflight}) < 3'd3)) begin
            rd_en = 1'b1;
        end
    end

    // Run/drain control: a stop request finishes the burst currently being issued.
    always_ff @(posedge rdclk) begin
        if (!rrst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if ((issue_beat == '0) && !inflight && (occ == 2'd0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue tagging, capture into the ring buffer, and stream-side pop.
    always_ff @(posedge rdclk) begin
        if (!rrst_n) begin
            occ        <= 2'd0;
            head       <= 2'd0;
            tail       <= 2'd0;
            inflight   <= 1'b0;
            last_q     <= 1'b0;
            issue_beat <= '0;
            word_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                last_q     <= beat_last;
                issue_beat <= beat_last ? '0 : issue_beat + BEAT_W'(1);
            end
            if (inflight) begin
                buf_data[tail] <= fifo_data;
                buf_last[tail] <= last_q;
                tail           <= ptr_next(tail);
            end
            if (pop) begin
                head       <= ptr_next(head);
                word_count <= word_count + CNT_WIDTH'(1);
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: FIFO model + scoreboard of expected words,
// with a separate monitor checking every stream handshake.
module tb_fifo_rd_streamer;

    localparam int unsigned W  = 64;
    localparam int unsigned BL = 4;
    localparam int unsigned CW = 32;

    logic          rdclk = 1'b0;
    logic          rrst_n;
    logic          enable;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic [CW-1:0] word_count;

    fifo_rd_streamer #(.FIFO_WIDTH(W), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .rdclk      (rdclk),
        .rrst_n     (rrst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .rd_en      (rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 rdclk = ~rdclk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    int           checks   = 0;
    int           failures = 0;
    exp_t         exp_q[$];
    logic [W-1:0] fq[$];
    int           pop_idx   = 0;
    int           pops      = 0;
    int           delivered = 0;
    int           rdy_mode  = 1;
    bit           tog_mode  = 0;
    bit           tog       = 0;
    logic         s_rd_en;
    logic         s_valid;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    exp_t         mon_e;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // One clock cycle: sample at negedge, then act as the FIFO after the posedge.
    task automatic step();
        logic pop_now;
        logic rst_seen;
        exp_t e;
        @(negedge rdclk);
        s_rd_en  = rd_en;
        s_valid  = m_valid;
        rst_seen = !rrst_n;
        if (fifo_empty) chk("rd_en_while_empty", 64'(rd_en), 64'd0);
        if (!rrst_n)    chk("rd_en_in_reset", 64'(rd_en), 64'd0);
        pop_now = rd_en && !fifo_empty && (fq.size() != 0);
        @(posedge rdclk);
        #1;
        if (rst_seen) begin
            exp_q.delete();
            pop_idx   = 0;
            delivered = 0;
        end
        if (pop_now) begin
            e.d = fq.pop_front();
            e.l = ((pop_idx % BL) == (BL - 1));
            pop_idx++;
            pops++;
            exp_q.push_back(e);
            fifo_data = e.d;
        end else begin
            fifo_data = {$urandom, $urandom};
        end
        tog = ~tog;
        fifo_empty = (fq.size() == 0) || (tog_mode && tog);
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_reset();
        rrst_n   = 1'b0;
        enable   = 1'b0;
        fq.delete();
        rdy_mode = 1;
        m_ready  = 1'b1;
        tog_mode = 0;
        pops     = 0;
        step();
        step();
        rrst_n = 1'b1;
    endtask

    task automatic load(input int n, input logic [W-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fq.push_back(rnd ? {$urandom, $urandom} : base + W'(i));
        end
        fifo_empty = (fq.size() == 0) || (tog_mode && tog);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_all_delivered"}, 64'(fq.size() + exp_q.size()), 64'd0);
    endtask

    // Monitor: checks each handshake against the scoreboard and stall stability.
    always @(negedge rdclk) begin
        if (!rrst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got=0x%0h expected=none", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_data", m_data, mon_e.d);
                    chk("stream_last", 64'(m_last), 64'(mon_e.l));
                end
                chk("word_count_at_xfer", 64'(word_count), 64'(delivered));
                delivered++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_rd;
        rrst_n     = 1'b0;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_ready    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);

        // Basic streaming: latency and back-to-back delivery of 8 words
        do_reset();
        load(8, 64'h0, 0);
        enable = 1'b1;
        step(); chk("t1_no_rd_en_in_idle", 64'(s_rd_en), 64'd0);
        step(); chk("t1_first_rd_en", 64'(s_rd_en), 64'd1);
        step(); chk("t1_valid_not_yet", 64'(s_valid), 64'd0);
        step(); chk("t1_first_valid", 64'(s_valid), 64'd1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t1_back_to_back", 64'(s_valid), 64'd1);
        end
        drain("t1", 50);
        chk("t1_word_count", 64'(word_count), 64'd8);

        // Backpressure: buffer fills to 3, then releases in order
        do_reset();
        load(8, 64'h0, 0);
        rdy_mode = 0;
        m_ready  = 1'b0;
        enable   = 1'b1;
        n_rd = 0;
        repeat (20) begin
            step();
            if (s_rd_en) n_rd++;
        end
        chk("t2_rd_en_pulses", 64'(n_rd), 64'd3);
        chk("t2_valid_stalled", 64'(m_valid), 64'd1);
        chk("t2_stuck_data", m_data, 64'h0);
        rdy_mode = 1;
        m_ready  = 1'b1;
        drain("t2", 60);
        chk("t2_word_count", 64'(word_count), 64'd8);

        // Stop mid-burst: completes the current burst, then idles
        do_reset();
        load(16, 64'd100, 0);
        enable = 1'b1;
        n = 0;
        while (pops < 2 && n < 20) begin step(); n++; end
        enable = 1'b0;
        n = 0;
        while (busy && n < 60) begin step(); n++; end
        chk("t3_busy_cleared", 64'(busy), 64'd0);
        chk("t3_pops", 64'(pops), 64'd4);
        chk("t3_word_count", 64'(word_count), 64'd4);
        chk("t3_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Intermittently empty FIFO
        do_reset();
        tog_mode = 1;
        load(6, 64'd200, 0);
        enable = 1'b1;
        drain("t4", 80);
        chk("t4_word_count", 64'(word_count), 64'd6);
        tog_mode = 0;

        // Reset with occ=2 and one word in flight
        do_reset();
        load(8, 64'd300, 0);
        rdy_mode = 0;
        m_ready  = 1'b0;
        enable   = 1'b1;
        n = 0;
        while (pops < 3 && n < 20) begin step(); n++; end
        chk("t5_pre_valid", 64'(m_valid), 64'd1);
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        chk("t5_post_valid", 64'(m_valid), 64'd0);
        chk("t5_post_word_count", 64'(word_count), 64'd0);
        chk("t5_post_busy", 64'(busy), 64'd0);
        rdy_mode = 1;
        m_ready  = 1'b1;
        drain("t5", 60);
        chk("t5_word_count", 64'(word_count), 64'd5);

        // Random backpressure over 100 random words
        do_reset();
        load(100, 64'h0, 1);
        rdy_mode = 2;
        enable   = 1'b1;
        drain("t6", 3000);
        chk("t6_word_count", 64'(word_count), 64'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
